spi_prot_trig: RTL



---
 rtl/spi_prot_trig.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spi_prot_trig.sv
// spi_prot_trig: SPI frame deserialiser with a masked-pattern trigger.
// Define SPI_TRIG_CNT_EN to build the saturating trig_cnt counter.
module spi_prot_trig #(
    parameter int MAX_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           SS_n,
    input  logic                           SCLK,
    input  logic                           MOSI,
    input  logic                           en,
    input  logic                           edge_sel,
    input  logic [$clog2(MAX_WIDTH+1)-1:0] frame_len,
    input  logic [MAX_WIDTH-1:0]           match,
    input  logic [MAX_WIDTH-1:0]           mask,
    output logic                           trig,
    output logic                           frame_done,
    output logic [MAX_WIDTH-1:0]           rx_data,
    output logic                           busy,
    output logic [15:0]                    trig_cnt
);
    localparam int LW = $clog2(MAX_WIDTH + 1);
    localparam int CW = $clog2(MAX_WIDTH + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;

    logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
    logic                   ss_hist, sck_hist;
    logic                   ss_s, sck_s, mosi_s;
    logic                   ss_fall, ss_rise, sck_rise, sck_fall;

    logic                 edge_q;
    logic [LW-1:0]        len_q;
    logic [MAX_WIDTH-1:0] match_q, mask_q;
    logic [MAX_WIDTH-1:0] shift, sh_n, lmask;
    logic [CW-1:0]        cnt, cnt_n;
    logic                 ovr, ovr_n;
    logic                 start, step, fin, len_ok, hit;

    function automatic logic [MAX_WIDTH-1:0] len_mask(input logic [LW-1:0] n);
        logic [MAX_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WIDTH; i++)
            if (32'(i) < 32'(n)) m[i] = 1'b1;
        return m;
    endfunction

    // Sync chains reset low so a frame already under way is never re-entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_hist   <= 1'b0;
            sck_hist  <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_hist   <= ss_s;
            sck_hist  <= sck_s;
        end
    end

    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ss_fall  = ss_hist & ~ss_s;
    assign ss_rise  = ~ss_hist & ss_s;
    assign sck_rise = ~sck_hist & sck_s;
    assign sck_fall = sck_hist & ~sck_s;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        step    = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en && ss_fall) begin
                    start   = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    state_n = IDLE;
                end else begin
                    step = edge_q ? sck_rise : sck_fall;
                    if (ss_rise) begin
                        fin     = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next shift/count values feed the compare so a final edge
    // coinciding with SS_n rise is included.
    always_comb begin
        sh_n  = shift;
        cnt_n = cnt;
        ovr_n = ovr;
        if (step) begin
            sh_n = {shift[MAX_WIDTH-2:0], mosi_s};
            if (cnt != CNT_MAX) cnt_n = cnt + CW'(1);
            if (32'(cnt) + 32'd1 > 32'(len_q)) ovr_n = 1'b1;
        end
    end

    assign lmask  = len_mask(len_q);
    assign len_ok = (len_q != '0) && (32'(len_q) <= 32'(MAX_WIDTH));
    assign hit    = len_ok && !ovr_n
                 && (32'(cnt_n) == 32'(len_q))
                 && (((sh_n ^ match_q) & mask_q & lmask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q     <= 1'b0;
            len_q      <= '0;
            match_q    <= '0;
            mask_q     <= '0;
            shift      <= '0;
            cnt        <= '0;
            ovr        <= 1'b0;
            rx_data    <= '0;
            trig       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            trig       <= 1'b0;
            frame_done <= 1'b0;
            if (start) begin
                edge_q  <= edge_sel;
                len_q   <= frame_len;
                match_q <= match;
                mask_q  <= mask;
                shift   <= '0;
                cnt     <= '0;
                ovr     <= 1'b0;
            end else begin
                shift <= sh_n;
                cnt   <= cnt_n;
                ovr   <= ovr_n;
            end
            if (fin) begin
                frame_done <= 1'b1;
                trig       <= hit;
                rx_data    <= sh_n & lmask;
            end
        end
    end

    assign busy = (state == SHIFT);

`ifdef SPI_TRIG_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            trig_cnt <= '0;
        else if (trig && trig_cnt != 16'hFFFF)
            trig_cnt <= trig_cnt + 16'd1;
    end
`else
    assign trig_cnt = 16'h0000;
`endif

endmodule
